avalon_bus_arbiter2: RTL and testbench

- Two-host to one-device Avalon-MM arbiter downstream of the core's bus ports.
- Host 0 connects to the core data bus and host 1 to the core instruction bus; the single device port goes to unified memory or the system bus.
- Supports pipelined reads with variable latency. An in-order grant-ID FIFO routes each readdata beat back to the host that issued it.

---
 rtl/avalon_bus_arbiter2.sv | 101 ++++++++++
 tb/tb_avalon_bus_arbiter2.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_bus_arbiter2.sv
// avalon_bus_arbiter2: two-host Avalon-MM arbiter with lock-on-stall and in-order read routing; ARB_ROUND_ROBIN_EN selects round-robin contention
module avalon_bus_arbiter2 #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    h0_read,
  input  logic                    h0_write,
  input  logic [ADDR_WIDTH-1:0]   h0_address,
  input  logic [DATA_WIDTH-1:0]   h0_writedata,
  input  logic [DATA_WIDTH/8-1:0] h0_byteenable,
  output logic                    h0_waitrequest,
  output logic [DATA_WIDTH-1:0]   h0_readdata,
  output logic                    h0_readdatavalid,
  input  logic                    h1_read,
  input  logic                    h1_write,
  input  logic [ADDR_WIDTH-1:0]   h1_address,
  input  logic [DATA_WIDTH-1:0]   h1_writedata,
  input  logic [DATA_WIDTH/8-1:0] h1_byteenable,
  output logic                    h1_waitrequest,
  output logic [DATA_WIDTH-1:0]   h1_readdata,
  output logic                    h1_readdatavalid,
  output logic                    d_read,
  output logic                    d_write,
  output logic [ADDR_WIDTH-1:0]   d_address,
  output logic [DATA_WIDTH-1:0]   d_writedata,
  output logic [DATA_WIDTH/8-1:0] d_byteenable,
  input  logic                    d_waitrequest,
  input  logic [DATA_WIDTH-1:0]   d_readdata,
  input  logic                    d_readdatavalid,
  output logic                    err_unexpected_rdata
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  logic lock_valid, lock_id, grant, contend_id, req0, req1, g_read, g_write;
  logic full, empty, accept, push, pop, head;
  logic [MAX_OUTSTANDING-1:0] ids;
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] count;
  assign req0 = h0_read | h0_write;
  assign req1 = h1_read | h1_write;
`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last;
  assign contend_id = ~rr_last;
`else
  assign contend_id = 1'b0;
`endif
  assign grant   = lock_valid ? lock_id : (req0 & req1) ? contend_id : req1;
  assign g_read  = grant ? h1_read : h0_read;
  assign g_write = grant ? h1_write : h0_write;
  assign full    = count[PW];
  assign empty   = count == '0;
  assign head    = ids[rptr];
  assign d_read       = g_read & ~full;
  assign d_write      = g_write;
  assign d_address    = grant ? h1_address : h0_address;
  assign d_writedata  = grant ? h1_writedata : h0_writedata;
  assign d_byteenable = grant ? h1_byteenable : h0_byteenable;
  assign accept = (d_read | d_write) & ~d_waitrequest;
  assign push   = accept & d_read;
  assign pop    = d_readdatavalid & ~empty;
  assign h0_waitrequest   = req0 & (grant | d_waitrequest | (h0_read & full));
  assign h1_waitrequest   = req1 & (~grant | d_waitrequest | (h1_read & full));
  assign h0_readdata      = d_readdata;
  assign h1_readdata      = d_readdata;
  assign h0_readdatavalid = pop & ~head;
  assign h1_readdatavalid = pop & head;
  // hold the bus for a granted host whose request was not accepted
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      lock_valid <= 1'b0;
      lock_id    <= 1'b0;
    end else begin
      lock_valid <= (g_read | g_write) & ~accept;
      lock_id    <= grant;
    end
  // grant-ID FIFO: one entry per accepted read, popped by each returned beat
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ids   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) ids[wptr] <= grant;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  // sticky flag for readdata arriving with nothing outstanding
  always_ff @(posedge clk or posedge rst)
    if (rst) err_unexpected_rdata <= 1'b0;
    else if (d_readdatavalid & empty) err_unexpected_rdata <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
  // remember the last host served so contention alternates
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_last <= 1'b1;
    else if (accept) rr_last <= grant;
`endif
endmodule

// File: tb/tb_avalon_bus_arbiter2.sv
// tb_avalon_bus_arbiter2: directed and random checks of the two-host arbiter against a transaction-level model
module tb_avalon_bus_arbiter2;
  localparam int MAX = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic h0_read, h0_write, h1_read, h1_write;
  logic [31:0] h0_address, h1_address, h0_writedata, h1_writedata;
  logic [3:0] h0_byteenable, h1_byteenable;
  logic h0_waitrequest, h1_waitrequest, h0_readdatavalid, h1_readdatavalid;
  logic [31:0] h0_readdata, h1_readdata;
  logic d_read, d_write, d_waitrequest, d_readdatavalid, err_unexpected_rdata;
  logic [31:0] d_address, d_writedata, d_readdata;
  logic [3:0] d_byteenable;
  int checks = 0, errors = 0;
  int owner, seen1;
  bit merr, rr, ew0, ew1;
  int q[$];
  logic [31:0] dev[$], hq0[$], hq1[$];

  avalon_bus_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .h0_read(h0_read), .h0_write(h0_write), .h0_address(h0_address), .h0_writedata(h0_writedata),
    .h0_byteenable(h0_byteenable), .h0_waitrequest(h0_waitrequest), .h0_readdata(h0_readdata),
    .h0_readdatavalid(h0_readdatavalid),
    .h1_read(h1_read), .h1_write(h1_write), .h1_address(h1_address), .h1_writedata(h1_writedata),
    .h1_byteenable(h1_byteenable), .h1_waitrequest(h1_waitrequest), .h1_readdata(h1_readdata),
    .h1_readdatavalid(h1_readdatavalid),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .d_readdatavalid(d_readdatavalid), .err_unexpected_rdata(err_unexpected_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    q.delete();
    dev.delete();
    hq0.delete();
    hq1.delete();
    owner = -1;
    merr = 1'b0;
    rr = 1'b1;
    ew0 = 1'b0;
    ew1 = 1'b0;
  endtask

  // one clock: check outputs at negedge against the model, then advance the model at posedge
  task automatic cyc();
    bit r0, r1, gr, gw, full, acc, v0, v1;
    int g, id;
    logic [31:0] data;
    d_readdata = dev.size() > 0 ? dev[0] : 32'h0;
    @(negedge clk);
    r0 = h0_read | h0_write;
    r1 = h1_read | h1_write;
    full = q.size() == MAX;
    if (owner >= 0) g = owner;
    else if (r0 && r1) g = (RR && !rr) ? 1 : 0;
    else g = r1 ? 1 : 0;
    gr = g ? h1_read : h0_read;
    gw = g ? h1_write : h0_write;
    ew0 = r0 && (g != 0 || d_waitrequest || (h0_read && full));
    ew1 = r1 && (g != 1 || d_waitrequest || (h1_read && full));
    v0 = d_readdatavalid && q.size() > 0 && q[0] == 0;
    v1 = d_readdatavalid && q.size() > 0 && q[0] == 1;
    chk("d_read", d_read, gr && !full);
    chk("d_write", d_write, gw);
    chk("d_address", d_address, g ? h1_address : h0_address);
    chk("d_writedata", d_writedata, g ? h1_writedata : h0_writedata);
    chk("d_byteenable", d_byteenable, g ? h1_byteenable : h0_byteenable);
    chk("h0_wait", h0_waitrequest, ew0);
    chk("h1_wait", h1_waitrequest, ew1);
    chk("h0_rdv", h0_readdatavalid, v0);
    chk("h1_rdv", h1_readdatavalid, v1);
    if (v0) chk("h0_rdata", h0_readdata, hq0[0]);
    if (v1) chk("h1_rdata", h1_readdata, hq1[0]);
    chk("err", err_unexpected_rdata, merr);
    if (h1_read && !h1_waitrequest) seen1++;
    @(posedge clk);
    acc = ((gr && !full) || gw) && !d_waitrequest;
    if (d_readdatavalid) begin
      if (q.size() > 0) begin
        id = q.pop_front();
        void'(dev.pop_front());
        if (id == 0) void'(hq0.pop_front());
        else void'(hq1.pop_front());
      end else merr = 1'b1;
    end
    if (acc && gr) begin
      data = $urandom;
      q.push_back(g);
      dev.push_back(data);
      if (g == 0) hq0.push_back(data);
      else hq1.push_back(data);
    end
    owner = ((gr || gw) && !acc) ? g : -1;
    if (acc) rr = (g == 1);
    #1;
  endtask

  initial begin
    int k;
    rst = 1'b1;
    {h0_read, h0_write, h1_read, h1_write, d_waitrequest, d_readdatavalid} = '0;
    {h0_address, h1_address, h0_writedata, h1_writedata, d_readdata} = '0;
    {h0_byteenable, h1_byteenable} = '0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d_read", d_read, 0);
    chk("rst_d_write", d_write, 0);
    chk("rst_h0_rdv", h0_readdatavalid, 0);
    chk("rst_h1_rdv", h1_readdatavalid, 0);
    chk("rst_err", err_unexpected_rdata, 0);
    rst = 1'b0;
    // simultaneous reads, device latency 2
    h0_read = 1; h0_address = 32'h10; h1_read = 1; h1_address = 32'h20;
    cyc();
    h0_read = 0;
    cyc();
    h1_read = 0; d_readdatavalid = 1;
    cyc();
    cyc();
    d_readdatavalid = 0;
    // host1 stalled three cycles; host0 must wait behind it
    h1_read = 1; h1_address = 32'h30; d_waitrequest = 1;
    cyc();
    h0_read = 1; h0_address = 32'h40;
    cyc();
    cyc();
    d_waitrequest = 0;
    cyc();
    h1_read = 0;
    cyc();
    h0_read = 0; d_readdatavalid = 1;
    cyc();
    cyc();
    d_readdatavalid = 0;
    // five back-to-back reads against a four-deep FIFO
    h0_read = 1;
    for (int i = 0; i < 4; i++) begin
      h0_address = 32'h100 + 4 * i;
      cyc();
    end
    h0_address = 32'h200;
    chk("full_block_wait", h0_waitrequest, 1);
    chk("full_block_dread", d_read, 0);
    cyc();
    d_readdatavalid = 1;
    cyc();
    d_readdatavalid = 0;
    cyc();
    h0_read = 0; d_readdatavalid = 1;
    repeat (4) cyc();
    d_readdatavalid = 0;
    // write from host0 against a concurrent host1 read
    h0_write = 1; h0_address = 32'h100; h0_writedata = 32'hDEADBEEF; h0_byteenable = 4'hF;
    h1_read = 1; h1_address = 32'h300;
    #1;
    chk("wr_d_write", d_write, 1);
    chk("wr_d_data", d_writedata, 32'hDEADBEEF);
    chk("wr_d_be", d_byteenable, 4'hF);
    chk("wr_d_addr", d_address, 32'h100);
    cyc();
    h0_write = 0;
    cyc();
    h1_read = 0; d_readdatavalid = 1;
    #1;
    chk("wr_only_h1_id", {h0_readdatavalid, h1_readdatavalid}, 2'b01);
    cyc();
    d_readdatavalid = 0;
    // stray readdatavalid, then asynchronous reset mid-transaction
    d_readdatavalid = 1;
    cyc();
    d_readdatavalid = 0;
    cyc();
    chk("err_sticky", err_unexpected_rdata, 1);
    h0_read = 1; h0_address = 32'h500;
    cyc();
    h0_read = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_err", err_unexpected_rdata, 0);
    chk("arst_d_read", d_read, 0);
    chk("arst_h0_wait", h0_waitrequest, 0);
    mreset();
    @(posedge clk);
    #1 rst = 1'b0;
    d_readdatavalid = 1;
    cyc();
    d_readdatavalid = 0;
    cyc();
    // continuous contention from both hosts
    rst = 1'b1;
    #1 mreset();
    @(posedge clk);
    #1 rst = 1'b0;
    seen1 = 0;
    h0_read = 1; h1_read = 1; h0_address = 32'h600; h1_address = 32'h700;
    for (int i = 0; i < 8; i++) begin
      d_readdatavalid = dev.size() > 0;
      cyc();
    end
    chk("contention_h1_grants", seen1, RR ? 4 : 0);
    h0_read = 0; h1_read = 0;
    for (int i = 0; i < 8 && dev.size() > 0; i++) begin
      d_readdatavalid = 1;
      cyc();
    end
    d_readdatavalid = 0;
    // random traffic with Avalon hold behaviour on both hosts
    for (int i = 0; i < 400; i++) begin
      if (!ew0) begin
        k = $urandom % 4;
        h0_read = (k == 1 || k == 2); h0_write = (k == 3);
        h0_address = $urandom; h0_writedata = $urandom; h0_byteenable = 4'($urandom);
      end
      if (!ew1) begin
        k = $urandom % 4;
        h1_read = (k == 1 || k == 2); h1_write = (k == 3);
        h1_address = $urandom; h1_writedata = $urandom; h1_byteenable = 4'($urandom);
      end
      d_waitrequest = ($urandom % 3) == 0;
      d_readdatavalid = dev.size() > 0 && ($urandom % 2) == 1;
      cyc();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
